// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MOD up/down counter built from JK flip-flops with load, clear, terminal count and wrap pulse
module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);
  logic [WIDTH-1:0] q_q, q_d, t;
  logic             wrap_q, wrap_d;
  always_comb begin
    t = clr ? '0
      : load ? (d > MAX ? MAX : d)
      : !en ? q_q
      : up_dn ? (q_q >= MAX ? '0 : q_q + 1'b1)
      : (q_q == '0 ? MAX : q_q - 1'b1);
    j = rst_n ? t & ~q_q : '0;
    k = rst_n ? ~t & q_q : '0;
    tc = rst_n & en & ~clr & ~load & (up_dn ? q_q == MAX : q_q == '0);
    // JK characteristic equation per bit
    q_d = (j & ~q_q) | (~k & q_q);
    wrap_d = tc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign q    = q_q;
  assign qbar = ~q_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: table vectors, hand corner sequences and randomized checks against an arithmetic model
module tb_jk_mod_counter;
  localparam int W = 4;
  localparam int M = 10;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0, clr = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q, qbar, j, k;
  logic tc, wrap;
  int n_chk = 0, n_fail = 0;
  int mq = 0, mw = 0;

  jk_mod_counter #(.WIDTH(W), .MOD(M)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .clr(clr),
    .d(d), .q(q), .qbar(qbar), .j(j), .k(k), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; checks combinational outputs, then the registered result.
  task automatic apply(input logic c, input logic l, input logic e, input logic u,
                       input logic [W-1:0] dv, output logic tc_pre);
    int t, mtc;
    clr = c; load = l; en = e; up_dn = u; d = dv;
    #1;
    if (c) t = 0;
    else if (l) t = (int'(dv) >= M) ? M - 1 : int'(dv);
    else if (e) t = u ? ((mq >= M - 1) ? 0 : mq + 1) : ((mq == 0) ? M - 1 : mq - 1);
    else t = mq;
    mtc = (e && !c && !l && ((u && mq == M - 1) || (!u && mq == 0))) ? 1 : 0;
    chk("j", j, (t & ~mq) & 15);
    chk("k", k, (~t & mq) & 15);
    chk("jk_overlap", j & k, 0);
    chk("tc", tc, mtc);
    tc_pre = tc;
    @(posedge clk);
    #1;
    mq = t;
    mw = mtc;
    chk("q", q, mq);
    chk("qbar", qbar, (~mq) & 15);
    chk("wrap", wrap, mw);
  endtask

  typedef struct {
    logic c, l, e, u;
    logic [W-1:0] dv;
    int exp_q, exp_tc, exp_wrap;
  } vec_t;

  vec_t tbl[$];
  logic tp;

  initial begin
    // up-count 12 edges from 0
    for (int i = 1; i <= 12; i++)
      tbl.push_back('{0, 0, 1, 1, 4'd0, i % 10, (i == 10) ? 1 : 0, (i == 10) ? 1 : 0});
    // down-count through the wrap
    tbl.push_back('{0, 0, 1, 0, 4'd0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 4'd0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 4'd0, 9, 1, 1});
    tbl.push_back('{0, 0, 1, 0, 4'd0, 8, 0, 0});
    // load, clamp, load-over-wrap
    tbl.push_back('{0, 1, 0, 1, 4'd5, 5, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 4'd13, 9, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 4'd0, 0, 0, 0});
    // priority
    tbl.push_back('{0, 1, 0, 1, 4'd6, 6, 0, 0});
    tbl.push_back('{1, 1, 1, 1, 4'd3, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 1, 4'd2, 2, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 4'd9, 2, 0, 0});

    en = 1'b1; up_dn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_qbar", qbar, 15);
    chk("rst_wrap", wrap, 0);
    chk("rst_tc", tc, 0);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].dv, tp);
      chk("tbl_q", q, tbl[i].exp_q);
      chk("tbl_tc", tp, tbl[i].exp_tc);
      chk("tbl_wrap", wrap, tbl[i].exp_wrap);
    end

    // excitation at q=7, then hold
    apply(0, 1, 0, 1, 4'd7, tp);
    clr = 0; load = 0; en = 1; up_dn = 1; #1;
    chk("exc_j7", j, 4'b1000);
    chk("exc_k7", k, 4'b0111);
    en = 0; #1;
    chk("hold_j", j, 0);
    chk("hold_k", k, 0);
    apply(0, 0, 0, 1, 4'd0, tp);
    chk("hold_q", q, 7);

    // down from 0, wrap pulse, then async reset with tc pending
    apply(1, 0, 0, 1, 4'd0, tp);
    clr = 0; en = 1; up_dn = 0; #1;
    chk("dn0_j", j, 4'b1001);
    chk("dn0_k", k, 4'b0000);
    chk("dn0_tc", tc, 1);
    apply(0, 0, 1, 0, 4'd0, tp);
    chk("dn_q9", q, 9);
    chk("dn_wrap", wrap, 1);
    up_dn = 1; #1;
    chk("pend_tc", tc, 1);
    rst_n = 0; #1;
    chk("arst_q", q, 0);
    chk("arst_qbar", qbar, 15);
    chk("arst_wrap", wrap, 0);
    chk("arst_tc", tc, 0);
    mq = 0; mw = 0;
    #2 rst_n = 1;
    apply(0, 0, 1, 1, 4'd0, tp);
    chk("resume_q", q, 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      apply($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
            1'($urandom_range(1)), 4'($urandom_range(15)), tp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits are edge-triggered JK flip-flops.
- Each bit's J/K excitation is derived from the excitation table, and the resulting j/k vectors are exported so the bench can check them.
- This block is the clocked consumer of JK latch behaviour in the sequential-circuits library. It wraps the JK hold/set/reset/toggle semantics in a counter with load, clear and terminal-count logic.
- It is the reference JK-based counter for the downstream divider and timer stages.

Parameters:
- WIDTH, 4, state width in bits.
- MOD, 10, count modulus. Legal range is 2..2^WIDTH. Count range is 0..MOD-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load of d.
- clr  input  1  synchronous clear to 0.
- d  input  WIDTH  load value.
- q  output  WIDTH  counter state (JK flip-flop outputs).
- qbar  output  WIDTH  bitwise complement of q.
- j  output  WIDTH  J excitation applied at the next edge (combinational).
- k  output  WIDTH  K excitation applied at the next edge (combinational).
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle pulse marking a wrap on the previous edge.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate, independent of clk):
  - q=0, qbar=all ones, wrap=0.
  - While rst_n=0: j=0, k=0 and tc=0.
  - Release is synchronous in effect: the first update happens on the first rising clk edge with rst_n=1.
- State element per bit i, updated on posedge clk:
  - q[i] <= (j[i] & ~q[i]) | (~k[i] & q[i]).
  - Resulting actions: 00 hold, 01 reset, 10 set, 11 toggle.
  - qbar is always ~q. There is no invalid or race state.
- Next target t is decided by priority clr > load > en > hold:
  - clr=1: t=0.
  - load=1: t=d. If d >= MOD, t=MOD-1 (saturating clamp).
  - en=1, up_dn=1: t = (q==MOD-1) ? 0 : q+1.
  - en=1, up_dn=0: t = (q==0) ? MOD-1 : q-1.
  - otherwise: t=q.
- Excitation (minimal form, don't-cares resolved to 0): j = t & ~q, k = ~t & q.
  - In hold, j=k=0 on every bit.
  - j&k is never 1 on any bit. The JK toggle path is legal but is not driven by this encoding.
- Latency: q reflects t exactly one clk edge after the inputs settle. Count, load and clear all take effect on the next edge.
- Terminal count:
  - tc = en & ~clr & ~load & ((up_dn & q==MOD-1) | (~up_dn & q==0)).
  - tc is high in the cycle before a wrap edge.
- wrap is registered: wrap <= tc at each edge. It therefore pulses for exactly one cycle after each wrap.
  - Load and clear never set wrap, including a load to 0 from MOD-1.
- Out-of-range state: q >= MOD is reachable only when MOD is not a power of 2, and only by faulty stimulus. Counting up from such a state goes to 0 on the next enabled edge; counting down decrements normally.
- MOD=2^WIDTH: natural binary wrap. The comparisons still apply.
- Simultaneous events:
  - clr+load+en: clear wins, wrap=0 next cycle.
  - load+en: load wins.
  - up_dn may change every cycle; it is sampled at each edge.
- Reset mid-count: q goes to 0 immediately, wrap clears, and any pending tc is dropped.

Test Plan (WIDTH=4, MOD=10):
- Reset then up-count: rst_n low 2 cycles, release, en=1, up_dn=1 for 12 edges → q sequence 1..9,0,1,2. tc=1 only while q=9. wrap=1 in the single cycle after q 9→0. qbar=~q throughout.
- Down-count wrap: from q=0, en=1, up_dn=0 → q=9, then 8. tc=1 at q=0. wrap pulses once. At q=0 → j=4'b1001, k=4'b0000.
- Excitation check: q=7, up → t=8, j=4'b1000, k=4'b0111. Hold (en=0) → j=k=0 and q stays 7.
- Load and clamp: load=1, d=5 → q=5. load=1, d=13 → q=9. load d=0 from q=9 with en=1 → q=0, wrap stays 0.
- Priority: clr=load=en=1, d=3, q=6 → q=0, tc=0, wrap=0. Then load=1 with en=1, d=2 → q=2.
- Async reset mid-operation: assert rst_n low between edges while q=8 → q=0 and qbar=4'b1111 before the next edge. wrap=0. Counting resumes from 1 after release.
